// File: rtl/match_filter_tx.sv
// Burst code modulator: emits the 2-bit-per-chip correlation code as signed I/Q chips, one per tx strobe.
// Optional feature macro MF_TX_REPEAT_EN: cstate 15 sets a repeat count; a burst sends the code rep+1 times.
module match_filter_tx #(
    parameter int unsigned MAX_CHIPS = 192,
    parameter logic [15:0] DEF_AMP   = 16'd8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        txstrobe,
    input  logic        start,
    input  logic [31:0] cdata,
    input  logic [3:0]  cstate,
    input  logic        cwrite,
    output logic [15:0] tx_i,
    output logic [15:0] tx_q,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [15:0] debugbus
);
    localparam int unsigned CODE_BITS = 2 * MAX_CHIPS;
    localparam logic [7:0]  MAX_LEN   = 8'(MAX_CHIPS);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

    state_t                 state_q;
    logic [7:0]             code_len_q;
    logic [15:0]            amp_q;
    logic [CODE_BITS-1:0]   code_q;
    logic [7:0]             chip_idx_q;
    logic [15:0]            tx_i_q;
    logic [15:0]            tx_q_q;
    logic                   tx_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   cfg_err_q;
`ifdef MF_TX_REPEAT_EN
    logic [7:0]             rep_q;
    logic [7:0]             rep_cnt_q;
`endif

    logic [7:0]  eff_len;
    logic [8:0]  bit_base;
    logic [1:0]  chip_bits;
    logic [15:0] amp_neg;
    logic [15:0] chip_i;
    logic [15:0] chip_q;
    logic [3:0]  word_sel;

    assign eff_len   = (code_len_q > MAX_LEN) ? MAX_LEN : code_len_q;
    assign bit_base  = {chip_idx_q, 1'b0};
    assign chip_bits = code_q[bit_base +: 2];
    // amp bit 15 is always 0, so the two's complement negation cannot overflow
    assign amp_neg   = 16'd0 - amp_q;
    assign chip_i    = chip_bits[1] ? amp_q : amp_neg;
    assign chip_q    = (chip_bits[1] == chip_bits[0]) ? amp_q : amp_neg;
    // cstate 3 maps to the top code word, cstate 13 to the second-lowest
    assign word_sel  = 4'd14 - cstate;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            code_len_q <= MAX_LEN;
            amp_q      <= DEF_AMP;
            code_q     <= '0;
            chip_idx_q <= 8'd0;
            tx_i_q     <= 16'd0;
            tx_q_q     <= 16'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
`ifdef MF_TX_REPEAT_EN
            rep_q      <= 8'd0;
            rep_cnt_q  <= 8'd0;
`endif
        end else begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;

            if (cwrite) begin
                if (state_q == IDLE) begin
                    if (cstate == 4'd1) begin
                        code_len_q <= cdata[7:0];
                    end else if (cstate == 4'd2) begin
                        amp_q <= {1'b0, cdata[14:0]};
                    end else if (cstate >= 4'd3 && cstate <= 4'd13) begin
                        code_q[{word_sel, 5'b0} +: 32] <= cdata;
`ifdef MF_TX_REPEAT_EN
                    end else if (cstate == 4'd15) begin
                        rep_q <= cdata[7:0];
`endif
                    end else begin
                        code_q[31:0] <= cdata;
                    end
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start && eff_len != 8'd0) begin
                        state_q    <= ARM;
                        chip_idx_q <= eff_len - 8'd1;
                        busy_q     <= 1'b1;
`ifdef MF_TX_REPEAT_EN
                        rep_cnt_q  <= rep_q;
`endif
                    end
                end
                ARM, SEND: begin
                    // the strobe that moves ARM to SEND already carries the first chip
                    if (txstrobe) begin
                        tx_i_q     <= chip_i;
                        tx_q_q     <= chip_q;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                        if (chip_idx_q == 8'd0) begin
`ifdef MF_TX_REPEAT_EN
                            if (rep_cnt_q != 8'd0) begin
                                rep_cnt_q  <= rep_cnt_q - 8'd1;
                                chip_idx_q <= eff_len - 8'd1;
                            end else begin
                                state_q <= DONE;
                            end
`else
                            state_q <= DONE;
`endif
                        end else begin
                            chip_idx_q <= chip_idx_q - 8'd1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    tx_i_q  <= 16'd0;
                    tx_q_q  <= 16'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_i     = tx_i_q;
    assign tx_q     = tx_q_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

`ifdef MF_TX_REPEAT_EN
    assign debugbus = {state_q, busy_q, done_q, tx_valid_q, cfg_err_q, txstrobe, start, rep_cnt_q};
`else
    assign debugbus = {state_q, busy_q, done_q, tx_valid_q, cfg_err_q, txstrobe, start, chip_idx_q};
`endif

endmodule

// File: tb/tb_match_filter_tx.sv
// Directed bench for match_filter_tx: hand-computed chip samples checked through an expected queue.
module tb_match_filter_tx;
    logic        clk;
    logic        reset;
    logic        txstrobe;
    logic        start;
    logic [31:0] cdata;
    logic [3:0]  cstate;
    logic        cwrite;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] debugbus;

    match_filter_tx dut (
        .clk      (clk),
        .reset    (reset),
        .txstrobe (txstrobe),
        .start    (start),
        .cdata    (cdata),
        .cstate   (cstate),
        .cwrite   (cwrite),
        .tx_i     (tx_i),
        .tx_q     (tx_q),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .debugbus (debugbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int last_valid_cyc = 0;
    int done_cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (tx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            chk("busy_at_valid", 32'(busy), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                chk("chip_sample", {tx_i, tx_q}, mon_exp);
            end else begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] cs, input logic [31:0] data);
        cstate = cs;
        cdata  = data;
        cwrite = 1'b1;
        tick();
        cwrite = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] q);
        exp_q.push_back({i, q});
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        done_cnt  = 0;
        exp_q.delete();
    endtask

    // Strobe every `period` cycles until done appears or the budget runs out
    task automatic run_burst(input int period, input int budget, input string tag);
        int busy_gaps;
        bit seen;
        busy_gaps = 0;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            txstrobe = (k % period == 0);
            tick();
            if (done) begin
                seen = 1'b1;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                chk({tag, "_zero_at_done"}, {tx_i, tx_q}, 32'd0);
            end else if (!busy) begin
                busy_gaps++;
            end
        end
        txstrobe = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_gaps"}, 32'(busy_gaps), 32'd0);
        tick();
    endtask

    task automatic check_burst_end(input string tag, input int exp_valid);
        chk({tag, "_valid_cnt"}, 32'(valid_cnt), 32'(exp_valid));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_valid_cyc), 32'd1);
    endtask

    initial begin
        int busy_hi;
        reset    = 1'b0;
        txstrobe = 1'b0;
        start    = 1'b0;
        cdata    = 32'd0;
        cstate   = 4'd0;
        cwrite   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_tx_i", 32'(tx_i), 32'd0);
        chk("rst_tx_q", 32'(tx_q), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_debug", 32'(debugbus), 32'd0);
        reset = 1'b1;
        tick();

        // Default config: 192 chips of code 00 at amp 8192 -> (-8192, +8192)
        clear_counts();
        for (int k = 0; k < 192; k++) push(16'hE000, 16'h2000);
        pulse_start();
        chk("def_busy_after_start", 32'(busy), 32'd1);
        chk("def_state_arm", 32'(debugbus[15:14]), 32'd1);
`ifndef MF_TX_REPEAT_EN
        chk("def_chip_idx", 32'(debugbus[7:0]), 32'd191);
`endif
        run_burst(4, 2000, "def");
        check_burst_end("def", 192);

        // Four-chip code 0xE4 at amp 1000
        cfg_write(4'd1, 32'd4);
        cfg_write(4'd2, 32'd1000);
        cfg_write(4'd0, 32'h0000_00E4);
        chk("idle_write_no_err", 32'(cfg_err), 32'd0);
        clear_counts();
        push(16'h03E8, 16'h03E8);
        push(16'h03E8, 16'hFC18);
        push(16'hFC18, 16'hFC18);
        push(16'hFC18, 16'h03E8);
        pulse_start();
        run_burst(3, 200, "e4");
        check_burst_end("e4", 4);

        // Strobe coincident with start is not consumed
        clear_counts();
        push(16'h03E8, 16'h03E8);
        push(16'h03E8, 16'hFC18);
        push(16'hFC18, 16'hFC18);
        push(16'hFC18, 16'h03E8);
        start    = 1'b1;
        txstrobe = 1'b1;
        tick();
        start    = 1'b0;
        txstrobe = 1'b0;
        chk("coinc_busy", 32'(busy), 32'd1);
        chk("coinc_no_valid0", 32'(tx_valid), 32'd0);
        repeat (4) tick();
        chk("coinc_no_valid4", 32'(tx_valid), 32'd0);
        chk("coinc_arm_zero", {tx_i, tx_q}, 32'd0);
        txstrobe = 1'b1;
        tick();
        txstrobe = 1'b0;
        chk("coinc_first_valid", 32'(tx_valid), 32'd1);
        chk("coinc_first_sample", {tx_i, tx_q}, 32'h03E8_03E8);
        tick();
        chk("coinc_valid_pulse", 32'(tx_valid), 32'd0);
        chk("coinc_hold", {tx_i, tx_q}, 32'h03E8_03E8);
        run_burst(2, 200, "coinc");
        check_burst_end("coinc", 4);

        // Config write and start mid-burst: rejected, amplitude unchanged
        clear_counts();
        push(16'h03E8, 16'h03E8);
        push(16'h03E8, 16'hFC18);
        push(16'hFC18, 16'hFC18);
        push(16'hFC18, 16'h03E8);
        pulse_start();
        txstrobe = 1'b1;
        tick();
        txstrobe = 1'b0;
        cstate = 4'd2;
        cdata  = 32'd500;
        cwrite = 1'b1;
        start  = 1'b1;
        tick();
        cwrite = 1'b0;
        start  = 1'b0;
        chk("mid_cfg_err", 32'(cfg_err), 32'd1);
        tick();
        chk("mid_cfg_err_pulse", 32'(cfg_err), 32'd0);
        run_burst(4, 200, "mid");
        check_burst_end("mid", 4);

        // Zero length: start ignored
        cfg_write(4'd1, 32'd0);
        clear_counts();
        pulse_start();
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_state", 32'(debugbus[15:14]), 32'd0);
        busy_hi = 0;
        for (int k = 0; k < 20; k++) begin
            txstrobe = (k % 2 == 0);
            tick();
            if (busy) busy_hi++;
        end
        txstrobe = 1'b0;
        tick();
        chk("zero_busy_hi", 32'(busy_hi), 32'd0);
        chk("zero_valid_cnt", 32'(valid_cnt), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd0);

        // Length 250 clamps to 192; chips 191..4 are code 00, 3..0 from 0xE4
        cfg_write(4'd1, 32'd250);
        clear_counts();
        for (int k = 191; k >= 4; k--) push(16'hFC18, 16'h03E8);
        push(16'h03E8, 16'h03E8);
        push(16'h03E8, 16'hFC18);
        push(16'hFC18, 16'hFC18);
        push(16'hFC18, 16'h03E8);
        pulse_start();
        run_burst(2, 1000, "clamp");
        check_burst_end("clamp", 192);

        // Reset after 10 chips aborts the burst
        clear_counts();
        for (int k = 0; k < 10; k++) push(16'hFC18, 16'h03E8);
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            txstrobe = 1'b1;
            tick();
            txstrobe = 1'b0;
            if (k < 9) tick();
        end
        chk("abort_last_valid", 32'(tx_valid), 32'd1);
        reset = 1'b0;
        tick();
        chk("abort_tx", {tx_i, tx_q}, 32'd0);
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("abort_valid_cnt", 32'(valid_cnt), 32'd10);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_exp_left", 32'(exp_q.size()), 32'd0);

        // Fresh burst after reset uses the reset config again
        clear_counts();
        for (int k = 0; k < 192; k++) push(16'hE000, 16'h2000);
        pulse_start();
        run_burst(2, 1000, "fresh");
        check_burst_end("fresh", 192);

`ifdef MF_TX_REPEAT_EN
        // rep=2, L=4: three passes back to back, single done
        cfg_write(4'd1, 32'd4);
        cfg_write(4'd15, 32'd2);
        clear_counts();
        for (int k = 0; k < 12; k++) push(16'hE000, 16'h2000);
        pulse_start();
        chk("rep_debug_cnt", 32'(debugbus[7:0]), 32'd2);
        run_burst(2, 200, "rep");
        check_burst_end("rep", 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
